// File: rtl/ro_sched_serializer.sv
// ro_sched_serializer: merges NCH comparator channels (pol / pol_eve lines)
// onto one output pair using a Gray-code slot scheduler.
//
// Ports:
//   clk, reset        - system clock, asynchronous active-high reset
//   en                - scheduler enable (event capture runs regardless)
//   in_pol[NCH]       - async comparator outputs
//   in_pol_eve[NCH]   - async comparator outputs, even phase
//   gray              - Gray-coded scheduler count
//   out_valid/out_ch  - current slot carries channel out_ch
//   out_mux_pol       - >=1 pol event in the reported window
//   out_mux_pol_eve   - >=1 pol_eve event in the reported window
//   out_multi         - >=2 events on one line merged in the window
//   frame_start       - one-cycle pulse after the counter wraps to 0
module ro_sched_serializer #(
    parameter int NCH   = 8,
    parameter int CNT_W = 17,
    parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [NCH-1:0]   in_pol,
    input  logic [NCH-1:0]   in_pol_eve,
    output logic [CNT_W-1:0] gray,
    output logic             out_valid,
    output logic [CH_W-1:0]  out_ch,
    output logic             out_mux_pol,
    output logic             out_mux_pol_eve,
    output logic             out_multi,
    output logic             frame_start
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] gray_q, gray_d;

    logic [NCH-1:0] pol_s1_q, pol_s2_q, pol_s3_q;
    logic [NCH-1:0] eve_s1_q, eve_s2_q, eve_s3_q;

    logic [NCH-1:0] hit_pol_q, hit_pol_d;
    logic [NCH-1:0] hit_eve_q, hit_eve_d;
    logic [NCH-1:0] multi_q, multi_d;

    logic            out_valid_q, out_valid_d;
    logic [CH_W-1:0] out_ch_q, out_ch_d;
    logic            out_pol_q, out_pol_d;
    logic            out_eve_q, out_eve_d;
    logic            out_multi_q, out_multi_d;
    logic            frame_start_q, frame_start_d;

    logic [NCH-1:0] grant;
    logic [NCH-1:0] ev_pol, ev_eve;
    logic           lower_set;

    always_comb begin
        cnt_d  = en ? cnt_q + CNT_W'(1) : cnt_q;
        gray_d = cnt_d ^ (cnt_d >> 1);

        // Slot owner is the lowest set bit of the new count (the Gray bit
        // that toggles). Counts whose low NCH bits are all zero are idle.
        grant     = '0;
        lower_set = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            grant[i]  = en & cnt_d[i] & ~lower_set;
            lower_set = lower_set | cnt_d[i];
        end

        ev_pol = pol_s2_q & ~pol_s3_q;
        ev_eve = eve_s2_q & ~eve_s3_q;

        // A granted channel starts a fresh window; an event landing on the
        // grant edge seeds that new window instead of the reported one.
        hit_pol_d = (hit_pol_q & ~grant) | ev_pol;
        hit_eve_d = (hit_eve_q & ~grant) | ev_eve;
        multi_d   = (multi_q
                    | (ev_pol & hit_pol_q)
                    | (ev_eve & hit_eve_q)
                    | (ev_pol & ev_eve & (hit_pol_q | hit_eve_q)))
                    & ~grant;

        out_valid_d = |grant;
        out_ch_d    = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                out_ch_d = CH_W'(i);
            end
        end
        out_pol_d     = |(grant & hit_pol_q);
        out_eve_d     = |(grant & hit_eve_q);
        out_multi_d   = |(grant & multi_q);
        frame_start_d = en & (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            gray_q        <= '0;
            pol_s1_q      <= '0;
            pol_s2_q      <= '0;
            pol_s3_q      <= '0;
            eve_s1_q      <= '0;
            eve_s2_q      <= '0;
            eve_s3_q      <= '0;
            hit_pol_q     <= '0;
            hit_eve_q     <= '0;
            multi_q       <= '0;
            out_valid_q   <= 1'b0;
            out_ch_q      <= '0;
            out_pol_q     <= 1'b0;
            out_eve_q     <= 1'b0;
            out_multi_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            gray_q        <= gray_d;
            pol_s1_q      <= in_pol;
            pol_s2_q      <= pol_s1_q;
            pol_s3_q      <= pol_s2_q;
            eve_s1_q      <= in_pol_eve;
            eve_s2_q      <= eve_s1_q;
            eve_s3_q      <= eve_s2_q;
            hit_pol_q     <= hit_pol_d;
            hit_eve_q     <= hit_eve_d;
            multi_q       <= multi_d;
            out_valid_q   <= out_valid_d;
            out_ch_q      <= out_ch_d;
            out_pol_q     <= out_pol_d;
            out_eve_q     <= out_eve_d;
            out_multi_q   <= out_multi_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign gray            = gray_q;
    assign out_valid       = out_valid_q;
    assign out_ch          = out_ch_q;
    assign out_mux_pol     = out_pol_q;
    assign out_mux_pol_eve = out_eve_q;
    assign out_multi       = out_multi_q;
    assign frame_start     = frame_start_q;

endmodule

// File: tb/tb_ro_sched_serializer.sv
// tb_ro_sched_serializer: directed bench for ro_sched_serializer
// (NCH=4, CNT_W=6) with a per-cycle reference model and literal checks.
module tb_ro_sched_serializer;

    localparam int NCH   = 4;
    localparam int CNT_W = 6;
    localparam int CH_W  = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [NCH-1:0]   in_pol;
    logic [NCH-1:0]   in_pol_eve;
    logic [CNT_W-1:0] gray;
    logic             out_valid;
    logic [CH_W-1:0]  out_ch;
    logic             out_mux_pol;
    logic             out_mux_pol_eve;
    logic             out_multi;
    logic             frame_start;

    ro_sched_serializer #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .en              (en),
        .in_pol          (in_pol),
        .in_pol_eve      (in_pol_eve),
        .gray            (gray),
        .out_valid       (out_valid),
        .out_ch          (out_ch),
        .out_mux_pol     (out_mux_pol),
        .out_mux_pol_eve (out_mux_pol_eve),
        .out_multi       (out_multi),
        .frame_start     (frame_start)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int ed     = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)",
                      name, act, exp, ed, $time);
    endtask

    function automatic int ctz(input int v);
        int r;
        r = 32;
        for (int i = 31; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    // Reference model: counter, event counts per window, input history.
    int       m_cnt;
    int       np[NCH];
    int       ne[NCH];
    bit [3:0] ph[NCH];
    bit [3:0] eh[NCH];
    int       e_valid, e_ch, e_pol, e_eve, e_multi, e_fs, e_gray;
    bit       model_on = 1'b0;

    always begin
        @(posedge clk);
        #1;
        e_valid = 0; e_ch = 0; e_pol = 0; e_eve = 0; e_multi = 0; e_fs = 0;
        if (reset) begin
            m_cnt = 0;
            for (int c = 0; c < NCH; c++) begin
                np[c] = 0; ne[c] = 0; ph[c] = '0; eh[c] = '0;
            end
        end else begin
            if (en) begin
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
                if (m_cnt == 0) e_fs = 1;
                else if (ctz(m_cnt) < NCH) begin
                    e_valid = 1;
                    e_ch    = ctz(m_cnt);
                    e_pol   = (np[e_ch] > 0) ? 1 : 0;
                    e_eve   = (ne[e_ch] > 0) ? 1 : 0;
                    e_multi = (np[e_ch] >= 2 || ne[e_ch] >= 2) ? 1 : 0;
                    np[e_ch] = 0;
                    ne[e_ch] = 0;
                end
            end
            // An input seen high at edge k-2 and low at k-3 counts at edge k.
            for (int c = 0; c < NCH; c++) begin
                ph[c] = {ph[c][2:0], in_pol[c]};
                eh[c] = {eh[c][2:0], in_pol_eve[c]};
                if (ph[c][2] && !ph[c][3]) np[c]++;
                if (eh[c][2] && !eh[c][3]) ne[c]++;
            end
        end
        e_gray = m_cnt ^ (m_cnt >> 1);
        if (model_on)
            check("model",
                  int'({gray, out_valid, out_ch, out_mux_pol,
                        out_mux_pol_eve, out_multi, frame_start}),
                  (e_gray << 7) | (e_valid << 6) | (e_ch << 4) |
                  (e_pol << 3) | (e_eve << 2) | (e_multi << 1) | e_fs);
    end

    task automatic run_to(input int k);
        while (ed < k) begin
            @(negedge clk);
            ed++;
        end
    endtask

    task automatic chk_zero(input string name);
        check(name, int'({gray, out_valid, out_ch, out_mux_pol,
                          out_mux_pol_eve, out_multi, frame_start}), 0);
    endtask

    int seq1[8] = '{0, 1, 0, 2, 0, 1, 0, 3};
    int seq2[4] = '{0, 1, 0, 2};

    initial begin
        reset      = 1'b1;
        en         = 1'b1;
        in_pol     = '0;
        in_pol_eve = '0;
        model_on   = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("reset_state");

        reset     = 1'b0;
        in_pol[0] = 1'b1;
        ed        = 0;

        for (int k = 1; k <= 8; k++) begin
            run_to(k);
            check("slot_valid", int'(out_valid), 1);
            check("slot_ch", int'(out_ch), seq1[k-1]);
            if (k == 2) in_pol[0] = 1'b0;
            if (k == 3) check("coinc_e3_pol", int'(out_mux_pol), 0);
            if (k == 4) in_pol[2] = 1'b1;
            if (k == 5) check("coinc_e5_pol", int'(out_mux_pol), 1);
            if (k == 6) in_pol_eve[3] = 1'b1;
            if (k == 7) in_pol[2] = 1'b0;
            if (k == 8) in_pol_eve[3] = 1'b0;
        end
        run_to(10);
        in_pol_eve[3] = 1'b1;
        run_to(12);
        in_pol_eve[3] = 1'b0;
        check("single_e12", int'({out_valid, out_ch, out_mux_pol, out_multi}),
              'b1_10_1_0);
        run_to(16);
        check("idle_e16", int'(out_valid), 0);
        run_to(20);
        check("single_e20", int'({out_valid, out_ch, out_mux_pol, out_multi}),
              'b1_10_0_0);
        run_to(24);
        check("merge_e24",
              int'({out_valid, out_ch, out_mux_pol_eve, out_multi}),
              'b1_11_1_1);
        run_to(40);
        check("merge_e40",
              int'({out_valid, out_ch, out_mux_pol, out_mux_pol_eve,
                    out_multi}), 'b1_11_0_0_0);
        run_to(64);
        check("wrap_e64", int'({frame_start, out_valid, gray}), 'b1_0_000000);

        run_to(70);
        en = 1'b0;
        for (int k = 71; k <= 80; k++) begin
            run_to(k);
            check("hold_gray", int'(gray), 5);
            check("hold_valid", int'(out_valid), 0);
            if (k == 72) in_pol[1] = 1'b1;
            if (k == 75) in_pol[1] = 1'b0;
            if (k == 80) en = 1'b1;
        end
        run_to(84);
        check("hold_e84", int'({out_valid, out_ch, out_mux_pol, gray}),
              'b1_01_1_001111);

        run_to(108);
        in_pol     = '1;
        in_pol_eve = '1;
        run_to(110);
        in_pol     = '0;
        in_pol_eve = '0;
        run_to(111);
        check("pre_reset_e111", int'({out_valid, out_ch, gray}), 'b1_00_110111);
        reset = 1'b1;
        #1;
        chk_zero("async_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ed    = 0;
        for (int k = 1; k <= 4; k++) begin
            run_to(k);
            check("post_reset_slot", int'({out_valid, out_ch}),
                  (1 << 2) | seq2[k-1]);
            check("post_reset_flags",
                  int'({out_mux_pol, out_mux_pol_eve, out_multi}), 0);
        end
        run_to(20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
